// File: rtl/wb_reg_bank_pkg.sv
// Shared constants, types and elaboration-time helpers for the Wishbone register bank.
// Register indices, the CPU control layout and the reset-stretcher state encoding live here.
`timescale 1ns/1ps
package wb_reg_bank_pkg;

   localparam int SYS_CLOCK_MHZ = 64;

   localparam int REG_CPU      = 0;
   localparam int REG_STATUS   = 1;
   localparam int REG_IRQ_MASK = 2;
   localparam int REG_ID       = 3;
   localparam int REG_COUNT    = 4;

   localparam int REG_CPU_READY_BIT = 0;
   localparam int REG_CPU_RESET_BIT = 1;

   // Bits needed to hold the value itself (minimum 1): 3 -> 2, 64 -> 7.
   function automatic int bit_width(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) <= value) w = i + 1;
      end
      return w;
   endfunction

   localparam int REG_ADDR_WIDTH = bit_width(REG_COUNT - 1);

   function automatic int ns_to_cycles(input int ns);
      return (ns * SYS_CLOCK_MHZ + 999) / 1000;
   endfunction

   typedef struct packed {
      logic reset;
      logic ready;
   } cpu_ctrl_t;

   typedef enum logic [1:0] {
      CPU_RST_RESET,
      CPU_RST_HOLD,
      CPU_RST_RUN
   } cpu_rst_state_t;

endpackage

// File: rtl/cpu_reset_stretcher.sv
// Holds the CPU in reset for a minimum number of cycles after the reset request is released.
// A re-asserted request during the hold aborts it; the next release restarts the full hold.
`timescale 1ns/1ps
module cpu_reset_stretcher
   import wb_reg_bank_pkg::*;
#(
   parameter int HOLD_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic reset_req_i,
   output logic cpu_reset_o
);

   localparam int EFF_CYCLES = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
   localparam int CNT_W      = bit_width(EFF_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EFF_CYCLES - 1);

   cpu_rst_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: every variable gets its default before the case so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CPU_RST_RESET: begin
            if (!reset_req_i) begin
               state_d = CPU_RST_HOLD;
               cnt_d   = CNT_LOAD;
            end
         end
         CPU_RST_HOLD: begin
            if (reset_req_i) begin
               state_d = CPU_RST_RESET;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = CPU_RST_RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         CPU_RST_RUN: begin
            if (reset_req_i) state_d = CPU_RST_RESET;
         end
         default: begin
            state_d = CPU_RST_RESET;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: state updates use non-blocking assignments; every register here is reset (no memories).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= CPU_RST_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cpu_reset_o = (state_q != CPU_RST_RUN);

endmodule

// File: rtl/wb_reg_bank.sv
// Wishbone classic slave register bank: CPU control, sticky W1C event status, IRQ mask, ID.
// One access per strobe assertion; the ack follows acceptance by exactly one cycle.
`timescale 1ns/1ps
module wb_reg_bank #(
   parameter int                    REG_COUNT     = wb_reg_bank_pkg::REG_COUNT,
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    ADDR_WIDTH    = wb_reg_bank_pkg::bit_width(REG_COUNT - 1),
   parameter int                    RESET_HOLD_NS = 1000,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE      = 8'hE1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   output logic                  wb_ack_o,
   input  logic [DATA_WIDTH-1:0] evt_i,
   output logic                  cpu_ready_o,
   output logic                  cpu_reset_o,
   output logic                  irq_o
);

   import wb_reg_bank_pkg::*;

   localparam int RESET_HOLD_CYCLES = ns_to_cycles(RESET_HOLD_NS);

   localparam logic [ADDR_WIDTH-1:0] ADR_CPU    = ADDR_WIDTH'(REG_CPU);
   localparam logic [ADDR_WIDTH-1:0] ADR_STATUS = ADDR_WIDTH'(REG_STATUS);
   localparam logic [ADDR_WIDTH-1:0] ADR_MASK   = ADDR_WIDTH'(REG_IRQ_MASK);
   localparam logic [ADDR_WIDTH-1:0] ADR_ID     = ADDR_WIDTH'(REG_ID);

   cpu_ctrl_t             ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0] status_q, status_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic [DATA_WIDTH-1:0] rdata, w1c;
   logic                  ack_q, req_q, irq_q, irq_d;
   logic                  req, accept, wr;

   // A held strobe is accepted only on its rising edge, so it can never re-trigger.
   assign req    = wb_cyc_i & wb_stb_i;
   assign accept = req & ~req_q;
   assign wr     = accept & wb_we_i;

   always_comb begin
      rdata = '0;
      case (wb_adr_i)
         ADR_CPU:    rdata = DATA_WIDTH'(ctrl_q);
         ADR_STATUS: rdata = status_q;
         ADR_MASK:   rdata = mask_q;
         ADR_ID:     rdata = ID_VALUE;
         default:    rdata = '0;
      endcase
   end

   always_comb begin
      ctrl_d = ctrl_q;
      mask_d = mask_q;
      w1c    = '0;
      if (wr) begin
         case (wb_adr_i)
            ADR_CPU:    ctrl_d = cpu_ctrl_t'(wb_dat_i[1:0]);
            ADR_STATUS: w1c    = wb_dat_i;
            ADR_MASK:   mask_d = wb_dat_i;
            default:    ;
         endcase
      end
      // New events win over a same-cycle clear of the same bit.
      status_d = (status_q & ~w1c) | evt_i;
      irq_d    = |(status_d & mask_d);
      dat_d    = accept ? (wb_we_i ? '0 : rdata) : dat_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ctrl_q   <= '{reset: 1'b1, ready: 1'b0};
         status_q <= '0;
         mask_q   <= '0;
         dat_q    <= '0;
         ack_q    <= 1'b0;
         req_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         status_q <= status_d;
         mask_q   <= mask_d;
         dat_q    <= dat_d;
         ack_q    <= accept;
         req_q    <= req;
         irq_q    <= irq_d;
      end
   end

   cpu_reset_stretcher #(
      .HOLD_CYCLES(RESET_HOLD_CYCLES)
   ) u_stretcher (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .reset_req_i (ctrl_q.reset),
      .cpu_reset_o (cpu_reset_o)
   );

   assign wb_dat_o    = dat_q;
   assign wb_ack_o    = ack_q;
   assign cpu_ready_o = ctrl_q.ready;
   assign irq_o       = irq_q;

endmodule
